// File: rtl/scl180_spare_pkg.sv
// rtl/scl180_spare_pkg.sv - shared types and constants for the spare-cell monitor
package scl180_spare_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam int DCNT_W = 4;
    localparam int FCNT_W = 8;
    localparam logic [FCNT_W-1:0] FCNT_MAX = 8'd255;

endpackage

// File: rtl/scl180_sync2.sv
// rtl/scl180_sync2.sv - parameterized-width two-flop synchronizer
module scl180_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of asynchronous inputs; both stages clear to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/scl180_sparecell_monitor.sv
// rtl/scl180_sparecell_monitor.sv - round-robin debounced stuck-high monitor for spare-cell LO ties
module scl180_sparecell_monitor
    import scl180_spare_pkg::*;
#(
    parameter int NUM_SPARE = 4,
    parameter int DEBOUNCE  = 3,
    parameter int SCAN_DIV  = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 enable_i,
    input  logic                 clr_i,
    input  logic [NUM_SPARE-1:0] irq_mask_i,
    input  logic [NUM_SPARE-1:0] spare_lo_i,
    output logic [NUM_SPARE-1:0] fault_o,
    output logic [FCNT_W-1:0]    fault_cnt_o,
    output logic                 irq_o,
    output logic                 scan_done_o
);

    localparam int IDX_W  = (NUM_SPARE > 1) ? $clog2(NUM_SPARE) : 1;
    localparam int TICK_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SPARE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [DCNT_W-1:0] DB_FULL   = DCNT_W'(DEBOUNCE);
    localparam logic [DCNT_W-1:0] DB_EDGE   = DCNT_W'(DEBOUNCE - 1);

    state_t              state, state_nx;
    logic [TICK_W-1:0]   tick, tick_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [NUM_SPARE-1:0] s;
    logic [DCNT_W-1:0]   dcnt [NUM_SPARE];

    logic                sample_en;
    logic                s_cur;
    logic                set_evt;

    scl180_sync2 #(
        .WIDTH(NUM_SPARE)
    ) u_sync (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .d  (spare_lo_i),
        .q  (s)
    );

    assign sample_en   = (state == SAMPLE);
    assign s_cur       = s[idx];
    assign set_evt     = sample_en && s_cur && (dcnt[idx] == DB_EDGE);
    assign scan_done_o = (state == DONE);

    // Scan sequencer state, tick counter and spare index registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            tick  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            tick  <= tick_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state: wait SCAN_DIV ticks, visit each spare once, pulse done; disable forces IDLE.
    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                tick_nx = '0;
                idx_nx  = '0;
                if (enable_i) state_nx = WAIT;
            end
            WAIT: begin
                if (tick == TICK_LAST) begin
                    tick_nx  = '0;
                    idx_nx   = '0;
                    state_nx = SAMPLE;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            SAMPLE: begin
                if (idx == IDX_LAST) state_nx = DONE;
                else                 idx_nx   = idx + 1'b1;
            end
            DONE: begin
                tick_nx  = '0;
                state_nx = WAIT;
            end
            default: state_nx = IDLE;
        endcase
        if (!enable_i) begin
            state_nx = IDLE;
            tick_nx  = '0;
            idx_nx   = '0;
        end
    end

    // Debounce the sampled spare and latch sticky faults; clear has priority over a same-cycle event.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_SPARE; i++) dcnt[i] <= '0;
            fault_o     <= '0;
            fault_cnt_o <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < NUM_SPARE; i++) dcnt[i] <= '0;
            fault_o     <= '0;
            fault_cnt_o <= '0;
        end else if (sample_en) begin
            if (!s_cur)                 dcnt[idx] <= '0;
            else if (dcnt[idx] < DB_FULL) dcnt[idx] <= dcnt[idx] + 1'b1;
            if (set_evt) begin
                fault_o[idx] <= 1'b1;
                if (!fault_o[idx] && (fault_cnt_o != FCNT_MAX))
                    fault_cnt_o <= fault_cnt_o + 1'b1;
            end
        end
    end

    // Interrupt is the masked fault summary, registered.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) irq_o <= 1'b0;
        else          irq_o <= |(fault_o & irq_mask_i);
    end

endmodule

// File: tb/tb_scl180_sparecell_monitor.sv
// tb/tb_scl180_sparecell_monitor.sv - randomized self-checking bench for the spare-cell monitor
module tb_scl180_sparecell_monitor;

    localparam int NS  = 4;
    localparam int DB  = 3;
    localparam int SD  = 8;
    localparam int PER = SD + NS + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [NS-1:0] mask = '0;
    logic [NS-1:0] lo   = '0;
    logic [NS-1:0] fault;
    logic [7:0]    fcnt;
    logic          irq;
    logic          done;

    scl180_sparecell_monitor #(
        .NUM_SPARE(NS),
        .DEBOUNCE (DB),
        .SCAN_DIV (SD)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .enable_i   (en),
        .clr_i      (clr),
        .irq_mask_i (mask),
        .spare_lo_i (lo),
        .fault_o    (fault),
        .fault_cnt_o(fcnt),
        .irq_o      (irq),
        .scan_done_o(done)
    );

    always #5 clk = ~clk;

    // Reference model: scan position in the period, per-spare streak, sticky flags.
    int            m_pos;
    int            m_dcnt [NS];
    logic [NS-1:0] m_fault;
    int            m_fcnt;
    logic          m_irq;
    logic [NS-1:0] m_q1, m_q2;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_sample_idx();
        int ph;
        if (m_pos < 0) return -1;
        ph = m_pos % PER;
        if (ph >= SD && ph < SD + NS) return ph - SD;
        return -1;
    endfunction

    function automatic logic m_done();
        return (m_pos >= 0) && (m_pos % PER == PER - 1);
    endfunction

    task automatic model_reset();
        m_pos = -1;
        for (int i = 0; i < NS; i++) m_dcnt[i] = 0;
        m_fault = '0;
        m_fcnt  = 0;
        m_irq   = 1'b0;
        m_q1    = '0;
        m_q2    = '0;
    endtask

    task automatic model_step();
        int   k;
        logic irq_n;
        k     = m_sample_idx();
        irq_n = |(m_fault & mask);
        if (clr) begin
            for (int i = 0; i < NS; i++) m_dcnt[i] = 0;
            m_fault = '0;
            m_fcnt  = 0;
        end else if (k >= 0) begin
            if (!m_q2[k]) begin
                m_dcnt[k] = 0;
            end else if (m_dcnt[k] < DB) begin
                m_dcnt[k]++;
                if (m_dcnt[k] == DB) begin
                    if (!m_fault[k] && m_fcnt < 255) m_fcnt++;
                    m_fault[k] = 1'b1;
                end
            end
        end
        m_irq = irq_n;
        m_pos = !en ? -1 : (m_pos < 0 ? 0 : (m_pos + 1) % PER);
        m_q2  = m_q1;
        m_q1  = lo;
    endtask

    task automatic compare_outputs();
        chk("fault_o", fault, m_fault);
        chk("fault_cnt_o", fcnt, m_fcnt);
        chk("irq_o", irq, m_irq);
        chk("scan_done_o", done, m_done());
    endtask

    // Inputs are set at a negedge; this advances one clock and checks the next cycle.
    task automatic cycle();
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run_until_done();
        int b = 0;
        do begin
            cycle();
            b++;
        end while (!m_done() && b < 2 * PER);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_fault", fault, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_irq", irq, 0);
        chk("rst_done", done, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        int cnt;
        int b;
        model_reset();
        do_reset();

        // Quiet spares for five scans.
        en = 1'b1;
        for (int i = 0; i < 5 * PER + 2; i++) cycle();

        // Spare 2 stuck high: flagged after three scans, counted once.
        lo   = 4'b0100;
        mask = 4'b0100;
        for (int i = 0; i < 4 * PER + 3; i++) cycle();
        chk("s2_fault", fault, 4'b0100);
        chk("s2_fcnt", fcnt, 1);
        chk("s2_irq", irq, 1);
        for (int i = 0; i < PER; i++) cycle();
        chk("s2_fcnt_hold", fcnt, 1);

        // Interrupted streak on spare 1 never flags; a full streak does.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        lo  = 4'b0000;
        run_until_done();
        foreach (m_q1[j]) begin end
        begin
            int pat [6] = '{1, 1, 0, 1, 1, 1};
            for (int j = 0; j < 6; j++) begin
                lo = (pat[j] != 0) ? 4'b0010 : 4'b0000;
                run_until_done();
                chk("s3_fault1", fault[1], (j == 5) ? 1 : 0);
            end
        end

        // Clear coinciding with the fault-set event on spare 0.
        lo  = 4'b0011;
        cnt = 0;
        b   = 0;
        while (cnt == 0 && b < 6 * PER) begin
            if (m_sample_idx() == 0 && m_q2[0] && m_dcnt[0] == DB - 1) begin
                clr = 1'b1;
                cnt = 1;
            end
            cycle();
            clr = 1'b0;
            b++;
        end
        chk("s4_event_seen", cnt, 1);
        chk("s4_fault", fault, 0);
        chk("s4_fcnt", fcnt, 0);

        // Enable dropped during the sample of spare 1.
        b = 0;
        while (m_sample_idx() != 1 && b < 3 * PER) begin
            cycle();
            b++;
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        en  = 1'b1;
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (done !== 1'b1 && cnt < 40);
        chk("s5_reenable_latency", cnt, 13);

        // Random spares, masks, clears and enable drops.
        for (int i = 0; i < 2500; i++) begin
            en   = ($urandom_range(0, 49) != 0);
            clr  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) mask = NS'($urandom);
            for (int j = 0; j < NS; j++) lo[j] = ($urandom_range(0, 9) < 8);
            cycle();
        end
        clr = 1'b0;

        // Asynchronous reset in the middle of WAIT with faults set.
        en   = 1'b1;
        lo   = 4'b1111;
        mask = 4'b1111;
        b    = 0;
        while (!(m_fault != 0 && m_pos >= 0 && m_pos % PER > 1 && m_pos % PER < SD - 2) && b < 8 * PER) begin
            cycle();
            b++;
        end
        chk("s6_pre_fault", |fault, 1);
        do_reset();
        lo = 4'b0000;
        for (int i = 0; i < 2 * PER; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
